icb_mem_responder: RTL and testbench
====================================

Name: icb_mem_responder

Overview:
- ICB responder (slave end) of the LSU/D-cache-to-BIU command/response interface.
- Backs the interface with a single-port, word-wide synchronous SRAM.
- Accepts one command per cycle and returns in-order responses through a bounded response FIFO.
- Used as the on-chip data RAM behind the BIU and as the memory model in D-cache/I-cache benches.

Parameters:
ADW, 64, command address width
DW, 64, data width (one word = DW/8 bytes; wmask is DW/8 bits)
MEM_AW, 12, SRAM word-address width (2^MEM_AW words = 32KB at defaults)
BASE_ADDR, 64'h8000_0000, byte address of word 0; must be aligned to 2^(MEM_AW+3)
RSP_DEPTH, 4, response FIFO entries; maximum outstanding commands (power of 2, >=2)

Ports:
clk  in  1  clock
rstn  in  1  reset
icb_cmd_valid  in  1  command valid
icb_cmd_ready  out  1  command ready
icb_cmd_addr  in  ADW  byte address; bits[2:0] ignored
icb_cmd_read  in  1  1=read, 0=write
icb_cmd_wdata  in  DW  write data
icb_cmd_wmask  in  DW/8  byte-lane write enables
icb_rsp_valid  out  1  response valid
icb_rsp_ready  in  1  response ready
icb_rsp_rdata  out  DW  read data; 0 for writes and errors
icb_rsp_err  out  1  1 = address outside window

Behaviour:
- Interface: reset is rstn, asynchronous, active-low; clock is clk.
- Reset:
  - icb_cmd_ready=1; icb_rsp_valid=0, icb_rsp_rdata=0, icb_rsp_err=0.
  - FIFO empty; pipe stage invalid.
  - SRAM contents are not reset.
- Address decode:
  - hit = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 2^(MEM_AW+3)); compare at full ADW width, no overflow.
  - Word index = addr[MEM_AW+2:3].
- Accept: on a cycle with icb_cmd_valid & icb_cmd_ready.
- Ready rule: icb_cmd_ready = (fifo_count + pipe_valid) < RSP_DEPTH. It is a function of registered state only and never depends on icb_cmd_valid.
- Stage 0 (accept cycle T):
  - Write hit: bytes with wmask[i]=1 are written at the clk edge ending T; other bytes unchanged.
  - Read hit: SRAM read issued.
  - Miss: no SRAM access (writes dropped).
  - The pipe register captures {read, err=~hit}.
- Stage 1 (cycle T+1):
  - The entry pushes into the FIFO at the edge ending T+1.
  - rdata = SRAM output for a read hit; 0 for a write or a miss.
- Response:
  - icb_rsp_* are driven from the FIFO head; icb_rsp_valid = FIFO non-empty.
  - Pop on icb_rsp_valid & icb_rsp_ready.
  - Minimum latency: a response is valid in cycle T+2.
  - Sustained throughput is 1 response/cycle while icb_rsp_ready=1.
  - Payload is held stable while valid & !ready.
- Ordering:
  - Strictly in-order.
  - Read-after-write to the same word on consecutive accepts returns the new data.
  - Back-to-back writes to the same word with disjoint masks merge.
- Simultaneous push and pop: count is unchanged; a full FIFO with a pop in the same cycle does not raise cmd_ready until the next cycle (registered count).
- Full: with RSP_DEPTH outstanding and rsp_ready=0, cmd_ready=0 and no command is lost; cmd_ready returns 1 in the cycle after the first pop.
- Reset mid-operation: the FIFO and pipe are flushed immediately and in-flight responses are discarded. Writes already committed remain in the SRAM.

Decomposition:
- Package icb_pkg:
  - ADW/DW defaults and the DW/8 mask width.
  - Response struct {rdata, err}.
  - Default BASE_ADDR constant.
- Sub-module icb_rsp_fifo:
  - Synchronous FIFO, depth RSP_DEPTH, width DW+1.
  - Pointers with wrap bit; exposes count, full, empty.
- The SRAM is an inferred behavioural array inside the top; byte-mask write is a generate loop.

Test Plan:
- Single write then read: write 0x8000_0010, wdata 0x1122_3344_5566_7788, wmask 0xFF; read same address.
  - Expected: write rsp err=0, rdata=0; read rsp at T+2 with rdata=0x1122_3344_5566_7788.
- Partial mask: write 0xAAAA..AAAA, mask 0xFF; then 0x5555..5555, mask 0x0F; then read.
  - Expected: rdata=0xAAAA_AAAA_5555_5555.
- Out of range: read 0x7FFF_FFF8; write 0x8000_8000 (first word past the window); then read 0x8000_0000.
  - Expected: both out-of-range responses err=1, rdata=0; the in-window read is unaffected by the dropped write.
- Backpressure: rsp_ready=0 with 6 back-to-back reads issued.
  - Expected: exactly 4 accepted, then cmd_ready=0.
  - Raise rsp_ready: 4 responses in order, cmd_ready=1 the cycle after the first pop, remaining 2 accepted and returned in order.
- Streaming: 16 alternating write/read pairs to incrementing addresses with rsp_ready=1.
  - Expected: cmd_ready stays 1; one response per cycle after the initial 2-cycle latency; every read matches the preceding write.
- Reset mid-traffic: assert rstn=0 with 3 responses outstanding.
  - Expected: rsp_valid=0 immediately; after release cmd_ready=1 and no stale responses; a read of a previously written word returns its data.

Source files
------------

// File: rtl/icb_pkg.sv
// icb_pkg: shared widths, default window base and response record for the ICB memory responder.
// Rev 1.0
`default_nettype none

package icb_pkg;

  localparam int ICB_ADW = 64;
  localparam int ICB_DW  = 64;
  localparam int ICB_MW  = ICB_DW / 8;

  localparam logic [63:0] ICB_BASE_ADDR = 64'h8000_0000;

  typedef struct packed {
    logic [ICB_DW-1:0] rdata;
    logic              err;
  } icb_rsp_t;

  function automatic int mask_width(input int dw);
    return dw / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/icb_mem_responder_if.sv
// icb_mem_responder_if: ICB command/response bundle between requester (master) and memory (slave).
// Rev 1.0
`default_nettype none

interface icb_mem_responder_if
  import icb_pkg::*;
#(
  parameter int ADW = ICB_ADW,
  parameter int DW  = ICB_DW
);

  logic              icb_cmd_valid;
  logic              icb_cmd_ready;
  logic [ADW-1:0]    icb_cmd_addr;
  logic              icb_cmd_read;
  logic [DW-1:0]     icb_cmd_wdata;
  logic [DW/8-1:0]   icb_cmd_wmask;
  logic              icb_rsp_valid;
  logic              icb_rsp_ready;
  logic [DW-1:0]     icb_rsp_rdata;
  logic              icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    output icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

endinterface

`default_nettype wire

// File: rtl/icb_rsp_fifo.sv
// icb_rsp_fifo: synchronous response FIFO with wrap-bit pointers; storage is not reset.
// Rev 1.0
`default_nettype none

module icb_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == DEPTH[CW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/icb_mem_responder.sv
// icb_mem_responder: ICB slave backed by a byte-maskable synchronous SRAM, in-order responses via FIFO.
// Rev 1.0
`default_nettype none

module icb_mem_responder
  import icb_pkg::*;
#(
  parameter int              ADW       = ICB_ADW,
  parameter int              DW        = ICB_DW,
  parameter int              MEM_AW    = 12,
  parameter logic [ADW-1:0]  BASE_ADDR = ICB_BASE_ADDR[ADW-1:0],
  parameter int              RSP_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  icb_mem_responder_if.slave icb
);

  localparam int MW = mask_width(DW);
  localparam int CW = $clog2(RSP_DEPTH) + 1;

  // Window bounds carry one extra bit so BASE + size never wraps.
  localparam logic [ADW:0] WIN_LO   = {1'b0, BASE_ADDR};
  localparam logic [ADW:0] WIN_SIZE = {{ADW{1'b0}}, 1'b1} << (MEM_AW + 3);
  localparam logic [ADW:0] WIN_HI   = WIN_LO + WIN_SIZE;

  logic [ADW:0]      addr_ext;
  logic              hit;
  logic [MEM_AW-1:0] widx;
  logic              cmd_fire;
  logic              sram_we;
  logic              sram_re;
  wire  [DW-1:0]     sram_rdata;

  logic              pipe_valid;
  logic              pipe_read;
  logic              pipe_err;
  logic [DW-1:0]     s1_rdata;

  logic [DW:0]       fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              rsp_pop;
  logic [CW:0]       occupancy;

  assign addr_ext = {1'b0, icb.icb_cmd_addr};
  assign hit      = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
  assign widx     = icb.icb_cmd_addr[MEM_AW+2:3];

  // Ready looks only at registered occupancy, so it never combinationally follows cmd_valid.
  assign occupancy         = {1'b0, fifo_count} + {{CW{1'b0}}, pipe_valid};
  assign icb.icb_cmd_ready = ~fifo_full && (occupancy < RSP_DEPTH[CW:0]);

  assign cmd_fire = icb.icb_cmd_valid & icb.icb_cmd_ready;
  assign sram_we  = cmd_fire & ~icb.icb_cmd_read & hit;
  assign sram_re  = cmd_fire &  icb.icb_cmd_read & hit;

  for (genvar b = 0; b < MW; b++) begin : g_byte
    logic [7:0] bank [2**MEM_AW];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (sram_we && icb.icb_cmd_wmask[b]) bank[widx] <= icb.icb_cmd_wdata[b*8 +: 8];
      if (sram_re) rd_q <= bank[widx];
    end

    assign sram_rdata[b*8 +: 8] = rd_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_valid <= 1'b0;
      pipe_read  <= 1'b0;
      pipe_err   <= 1'b0;
    end else begin
      pipe_valid <= cmd_fire;
      if (cmd_fire) begin
        pipe_read <= icb.icb_cmd_read;
        pipe_err  <= ~hit;
      end
    end
  end

  assign s1_rdata = (pipe_valid && pipe_read && !pipe_err) ? sram_rdata : '0;

  assign rsp_pop = icb.icb_rsp_valid & icb.icb_rsp_ready;

  icb_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DW + 1),
    .CW    (CW)
  ) u_rsp_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (pipe_valid),
    .push_data ({s1_rdata, pipe_err}),
    .pop       (rsp_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Payload is forced to zero while empty so the outputs read as idle out of reset.
  assign icb.icb_rsp_valid = ~fifo_empty;
  assign {icb.icb_rsp_rdata, icb.icb_rsp_err} = fifo_empty ? '0 : fifo_head;

endmodule

`default_nettype wire

// File: tb/tb_icb_mem_responder.sv
// tb_icb_mem_responder: directed stimulus with a queue scoreboard checked by an independent monitor.
// Rev 1.0
`default_nettype none

module tb_icb_mem_responder;
  import icb_pkg::*;

  typedef struct {
    icb_rsp_t rsp;
    int       acc;
    bit       exact;
    int       id;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   rsp_id = 0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  icb_mem_responder_if #(.ADW(64), .DW(64)) icb ();

  icb_mem_responder #(
    .ADW       (64),
    .DW        (64),
    .MEM_AW    (12),
    .BASE_ADDR (64'h8000_0000),
    .RSP_DEPTH (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .icb  (icb)
  );

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] rdata, input bit err, input bit exact);
    exp_t e;
    e.rsp.rdata = rdata;
    e.rsp.err   = err;
    e.acc       = cyc;
    e.exact     = exact;
    e.id        = rsp_id;
    rsp_id++;
    q.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a response.
  always @(negedge clk) begin
    if (rstn && icb.icb_rsp_valid && icb.icb_rsp_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rdata %h err %b, required no response",
                 icb.icb_rsp_rdata, icb.icb_rsp_err);
      end else begin
        mon_e = q.pop_front();
        check64($sformatf("rsp%0d_rdata", mon_e.id), icb.icb_rsp_rdata, mon_e.rsp.rdata);
        check64($sformatf("rsp%0d_err", mon_e.id), {63'd0, icb.icb_rsp_err}, {63'd0, mon_e.rsp.err});
        if (mon_e.exact)
          check64($sformatf("rsp%0d_latency", mon_e.id), 64'(cyc - mon_e.acc), 64'd2);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds a command until accepted; expected response is queued on acceptance.
  task automatic drive_cmd(input bit rd, input logic [63:0] addr, input logic [63:0] wd,
                           input logic [7:0] wm, input logic [63:0] exp_rdata,
                           input bit exp_err, input bit exact, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    icb.icb_cmd_valid = 1'b1;
    icb.icb_cmd_read  = rd;
    icb.icb_cmd_addr  = addr;
    icb.icb_cmd_wdata = wd;
    icb.icb_cmd_wmask = wm;
    while (!done) begin
      @(negedge clk);
      if (icb.icb_cmd_ready) begin
        push_exp(exp_rdata, exp_err, exact);
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
      if (!done && waits > 50) begin
        tests++;
        fails++;
        $display("FAIL cmd_accept_timeout: got no accept for addr %h, required accept within 50 cycles", addr);
        done = 1'b1;
      end
    end
    icb.icb_cmd_valid = 1'b0;
  endtask

  initial begin
    int w;
    int wsum;
    int saw;
    logic [63:0] a;
    logic [63:0] d;

    icb.icb_cmd_valid = 1'b0;
    icb.icb_cmd_read  = 1'b0;
    icb.icb_cmd_addr  = '0;
    icb.icb_cmd_wdata = '0;
    icb.icb_cmd_wmask = '0;
    icb.icb_rsp_ready = 1'b1;

    #1;
    check64("reset_cmd_ready", {63'd0, icb.icb_cmd_ready}, 64'd1);
    check64("reset_rsp_valid", {63'd0, icb.icb_rsp_valid}, 64'd0);
    check64("reset_rsp_rdata", icb.icb_rsp_rdata, 64'd0);
    check64("reset_rsp_err", {63'd0, icb.icb_rsp_err}, 64'd0);
    idle(2);
    rstn = 1'b1;

    // Single write then read
    drive_cmd(0, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 0, 1, w);
    drive_cmd(1, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 0, 1, w);

    // Partial mask merge
    drive_cmd(0, 64'h8000_0018, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 64'd0, 0, 1, w);
    drive_cmd(0, 64'h8000_0018, 64'h5555_5555_5555_5555, 8'h0F, 64'd0, 0, 1, w);
    drive_cmd(1, 64'h8000_0018, 64'd0, 8'h00, 64'hAAAA_AAAA_5555_5555, 0, 1, w);

    // Out of range, including a write that would alias word 0 if decode were truncated
    drive_cmd(0, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, 0, 1, w);
    drive_cmd(1, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 1, 1, w);
    drive_cmd(0, 64'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1, 1, w);
    drive_cmd(1, 64'h8000_0000, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF, 0, 1, w);

    // Backpressure: four accepted back to back, fifth stalls
    idle(4);
    icb.icb_rsp_ready = 1'b0;
    wsum = 0;
    drive_cmd(1, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 0, 0, w); wsum += w;
    drive_cmd(1, 64'h8000_0018, 64'd0, 8'h00, 64'hAAAA_AAAA_5555_5555, 0, 0, w); wsum += w;
    drive_cmd(1, 64'h8000_0000, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF, 0, 0, w); wsum += w;
    drive_cmd(1, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 0, 0, w); wsum += w;
    check64("bp_first4_stalls", 64'(wsum), 64'd0);

    icb.icb_cmd_valid = 1'b1;
    icb.icb_cmd_read  = 1'b1;
    icb.icb_cmd_addr  = 64'h8000_0018;
    saw = 0;
    repeat (3) begin
      @(negedge clk);
      if (icb.icb_cmd_ready) saw++;
      @(posedge clk);
      #1;
    end
    check64("bp_ready_low_when_full", 64'(saw), 64'd0);
    icb.icb_rsp_ready = 1'b1;
    @(negedge clk);
    check64("bp_ready_in_pop_cycle", {63'd0, icb.icb_cmd_ready}, 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check64("bp_ready_after_pop", {63'd0, icb.icb_cmd_ready}, 64'd1);
    if (icb.icb_cmd_ready) push_exp(64'hAAAA_AAAA_5555_5555, 0, 0);
    @(posedge clk);
    #1;
    icb.icb_cmd_valid = 1'b0;
    drive_cmd(1, 64'h8000_0000, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF, 0, 0, w);

    // Streaming write/read pairs
    idle(6);
    wsum = 0;
    for (int k = 0; k < 16; k++) begin
      a = 64'h8000_0100 + 64'(k) * 64'd8;
      d = 64'hC0DE_0000_0000_0000 | (64'(k) * 64'h0000_0101_0101_0101);
      drive_cmd(0, a, d, 8'hFF, 64'd0, 0, 1, w); wsum += w;
      drive_cmd(1, a, 64'd0, 8'h00, d, 0, 1, w); wsum += w;
    end
    check64("stream_stalls", 64'(wsum), 64'd0);

    // Reset with responses outstanding
    idle(4);
    icb.icb_rsp_ready = 1'b0;
    drive_cmd(1, 64'h8000_0100, 64'd0, 8'h00, 64'd0, 0, 0, w);
    drive_cmd(1, 64'h8000_0108, 64'd0, 8'h00, 64'd0, 0, 0, w);
    drive_cmd(1, 64'h8000_0110, 64'd0, 8'h00, 64'd0, 0, 0, w);
    check64("rst_pending_valid", {63'd0, icb.icb_rsp_valid}, 64'd1);
    rstn = 1'b0;
    #1;
    check64("rst_rsp_valid_now", {63'd0, icb.icb_rsp_valid}, 64'd0);
    check64("rst_cmd_ready_now", {63'd0, icb.icb_cmd_ready}, 64'd1);
    q.delete();
    idle(2);
    rstn = 1'b1;
    icb.icb_rsp_ready = 1'b1;
    saw = 0;
    repeat (3) begin
      @(negedge clk);
      if (icb.icb_rsp_valid) saw++;
      if (!icb.icb_cmd_ready) saw += 100;
      @(posedge clk);
      #1;
    end
    check64("rst_no_stale_rsp", 64'(saw), 64'd0);
    drive_cmd(1, 64'h8000_0118, 64'd0, 8'h00,
              64'hC0DE_0000_0000_0000 | (64'd3 * 64'h0000_0101_0101_0101), 0, 1, w);

    for (int i = 0; i < 40 && q.size() > 0; i++) idle(1);
    idle(2);
    check64("drain_pending", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
